// File: rtl/eda_local_max_scan.sv
// eda_local_max_scan
// Walks every pixel of an M x N image in row-major order, presents each
// centre address to an external window RAM, and emits one "is local maximum"
// flag per pixel through a valid/ready output register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; centre address and max_count hold
// SCAN  | one pixel loaded into the output register per load cycle
// DRAIN | last pixel loaded, waiting for its result to be accepted
// DONE  | one-cycle done pulse, then back to IDLE
module eda_local_max_scan #(
  parameter int M            = 16,
  parameter int N            = 16,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WINDOW_WIDTH = 9,
  // A 1x1 image still needs a one-bit address bus.
  parameter int ADDR_WIDTH   = (M * N > 1) ? $clog2(M * N) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  output logic [ADDR_WIDTH-1:0]             center_addr,
  input  logic [PIXEL_WIDTH*WINDOW_WIDTH-1:0] window_values,
  input  logic [WINDOW_WIDTH-2:0]           neigh_addr_valid,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ADDR_WIDTH-1:0]             out_addr,
  output logic                              out_is_max,
  output logic                              busy,
  output logic                              done,
  output logic [ADDR_WIDTH:0]               max_count
);

  localparam int NUM_NEIGH = WINDOW_WIDTH - 1;
  localparam int CENTER_SLOT = NUM_NEIGH / 2;
  localparam logic [ADDR_WIDTH-1:0] LP_LAST_ADDR = ADDR_WIDTH'(M * N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [ADDR_WIDTH-1:0]   r_center;
  logic                    r_out_valid;
  logic [ADDR_WIDTH-1:0]   r_out_addr;
  logic                    r_out_is_max;
  logic [ADDR_WIDTH:0]     r_max_count;

  logic [PIXEL_WIDTH-1:0]  w_center_px;
  logic [PIXEL_WIDTH-1:0]  w_neigh [NUM_NEIGH];
  logic                    w_is_max;
  logic                    w_load;
  logic                    w_handshake;
  logic                    w_last;

  // Load whenever scanning and the output register is empty or being drained.
  assign w_load      = (r_state == SCAN) && (!r_out_valid || out_ready);
  assign w_handshake = r_out_valid && out_ready;
  assign w_last      = (r_center == LP_LAST_ADDR);

  // Split the packed window: slot 0 (MSB) is upleft, the middle slot is the
  // centre, neighbours are numbered in the same order skipping the centre.
  always_comb begin
    int k;
    k = 0;
    w_center_px = window_values[(WINDOW_WIDTH-1-CENTER_SLOT)*PIXEL_WIDTH +: PIXEL_WIDTH];
    for (int n = 0; n < NUM_NEIGH; n++) begin
      k = (n < CENTER_SLOT) ? n : n + 1;
      w_neigh[n] = window_values[(WINDOW_WIDTH-1-k)*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
  end

  // Centre is a maximum unless some valid neighbour is strictly larger;
  // plateaus therefore count as maxima.
  always_comb begin
    w_is_max = 1'b1;
    for (int n = 0; n < NUM_NEIGH; n++) begin
      if (neigh_addr_valid[NUM_NEIGH-1-n] && (w_neigh[n] > w_center_px)) begin
        w_is_max = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:  if (start) w_state_next = SCAN;
      SCAN:  if (w_load && w_last) w_state_next = DRAIN;
      DRAIN: if (w_handshake) w_state_next = DONE;
      DONE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Centre address, output register and maxima counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_center     <= '0;
      r_out_valid  <= 1'b0;
      r_out_addr   <= '0;
      r_out_is_max <= 1'b0;
      r_max_count  <= '0;
    end else begin
      if ((r_state == IDLE) && start) begin
        r_center    <= '0;
        r_max_count <= '0;
      end else if (w_load) begin
        // The last address is kept rather than wrapping back to zero.
        if (!w_last) begin
          r_center <= r_center + 1'b1;
        end
        if (w_is_max) begin
          r_max_count <= r_max_count + 1'b1;
        end
      end

      if (w_load) begin
        r_out_valid  <= 1'b1;
        r_out_addr   <= r_center;
        r_out_is_max <= w_is_max;
      end else if (w_handshake) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign center_addr = r_center;
  assign out_valid   = r_out_valid;
  assign out_addr    = r_out_addr;
  assign out_is_max  = r_out_is_max;
  assign max_count   = r_max_count;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);

endmodule

// File: tb/tb_eda_local_max_scan.sv
// Directed bench for eda_local_max_scan on a 4x4 image. The bench models the
// window RAM; positions outside the image read as 8'hFF so that ignoring
// invalid neighbours matters.
module tb_eda_local_max_scan;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int WW = 9;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [AW-1:0]   center_addr;
  logic [PW*WW-1:0] window_values;
  logic [WW-2:0]   neigh_addr_valid;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_addr;
  logic            out_is_max;
  logic            busy;
  logic            done;
  logic [AW:0]     max_count;

  logic [7:0] img [16];
  int total = 0;
  int bad   = 0;

  eda_local_max_scan #(
    .M(M), .N(N), .PIXEL_WIDTH(PW), .WINDOW_WIDTH(WW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .center_addr(center_addr),
    .window_values(window_values), .neigh_addr_valid(neigh_addr_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_is_max(out_is_max), .busy(busy), .done(done), .max_count(max_count)
  );

  always #5 clk = ~clk;

  // Window RAM model: combinational from center_addr.
  always_comb begin
    int ci, cj, r, c;
    bit inb;
    window_values    = '0;
    neigh_addr_valid = '0;
    ci = int'(center_addr[3:2]);
    cj = int'(center_addr[1:0]);
    r = 0; c = 0; inb = 1'b0;
    for (int k = 0; k < 9; k++) begin
      r = ci + k / 3 - 1;
      c = cj + k % 3 - 1;
      inb = (r >= 0) && (r < N) && (c >= 0) && (c < M);
      window_values[(8-k)*8 +: 8] = inb ? img[r*4+c] : 8'hFF;
      if (k < 4 && inb) neigh_addr_valid[7-k] = 1'b1;
      if (k > 4 && inb) neigh_addr_valid[8-k] = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind 0: flat 5; kind 1: 4i+j; kind 2: peak 200 at addr 5 on 10.
  task automatic set_img(input int kind);
    for (int a = 0; a < 16; a++) begin
      case (kind)
        0:       img[a] = 8'd5;
        1:       img[a] = 8'(a);
        default: img[a] = (a == 5) ? 8'd200 : 8'd10;
      endcase
    end
  endtask

  // Hand-derived maxima. For the peak image, pixels in row 3 / column 3 are
  // out of the peak's reach and sit on a flat background, so they are
  // plateau maxima too.
  function automatic logic exp_flag(input int kind, input int a);
    case (kind)
      0:       return 1'b1;
      1:       return (a == 15);
      default: return (a inside {3, 5, 7, 11, 12, 13, 14, 15});
    endcase
  endfunction

  // mode 0: out_ready held 1; mode 1: out_ready toggles each cycle.
  task automatic run_scan(input int kind, input int mode, input int extra_start_at,
                          input int exp_cnt, input string name);
    int idx, cyc, first_cyc, last_cyc;
    bit stalled;
    logic [AW-1:0] h_addr, h_center;
    logic h_flag;
    idx = 0; cyc = 0; first_cyc = -1; last_cyc = -1; stalled = 0;
    h_addr = '0; h_center = '0; h_flag = 1'b0;
    set_img(kind);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".busy_start"}, 32'(busy), 32'd1);
    chk({name, ".center_start"}, 32'(center_addr), 32'd0);
    chk({name, ".cnt_start"}, 32'(max_count), 32'd0);
    while (idx < 16 && cyc < 200) begin
      if (stalled) begin
        chk({name, ".hold_valid"}, 32'(out_valid), 32'd1);
        chk({name, ".hold_addr"}, 32'(out_addr), 32'(h_addr));
        chk({name, ".hold_flag"}, 32'(out_is_max), 32'(h_flag));
        chk({name, ".hold_center"}, 32'(center_addr), 32'(h_center));
      end
      start = (cyc == extra_start_at);
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      if (out_valid && out_ready) begin
        chk($sformatf("%s.addr%0d", name, idx), 32'(out_addr), 32'(idx));
        chk($sformatf("%s.flag%0d", name, idx), 32'(out_is_max), 32'(exp_flag(kind, idx)));
        if (idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
        stalled = 0;
      end else begin
        stalled  = out_valid;
        h_addr   = out_addr;
        h_flag   = out_is_max;
        h_center = center_addr;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({name, ".results"}, 32'(idx), 32'd16);
    if (mode == 0) chk({name, ".back_to_back"}, 32'(last_cyc - first_cyc), 32'd15);
    chk({name, ".done_pulse"}, 32'(done), 32'd1);
    chk({name, ".valid_clear"}, 32'(out_valid), 32'd0);
    chk({name, ".center_last"}, 32'(center_addr), 32'd15);
    chk({name, ".cnt"}, 32'(max_count), 32'(exp_cnt));
    @(negedge clk);
    chk({name, ".done_once"}, 32'(done), 32'd0);
    chk({name, ".busy_end"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk({name, ".idle_busy"}, 32'(busy), 32'd0);
    chk({name, ".cnt_hold"}, 32'(max_count), 32'(exp_cnt));
    chk({name, ".center_hold"}, 32'(center_addr), 32'd15);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    set_img(0);
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.cnt", 32'(max_count), 32'd0);
    chk("rst.center", 32'(center_addr), 32'd0);
    reset_n = 1'b1;

    run_scan(0, 0, -1, 16, "flat");
    run_scan(1, 0, -1, 1, "ramp");
    run_scan(2, 0, -1, 8, "peak");
    run_scan(1, 1, -1, 1, "toggle");
    run_scan(2, 0, 5, 8, "restart");

    // Reset while the 7th result (addr 6) of a flat scan is on the outputs.
    set_img(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_addr == 4'd6) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("midrst.reach", 32'(n < 50), 32'd1);
    chk("midrst.cnt_before", 32'(max_count), 32'd7);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst.valid", 32'(out_valid), 32'd0);
    chk("midrst.addr", 32'(out_addr), 32'd0);
    chk("midrst.flag", 32'(out_is_max), 32'd0);
    chk("midrst.center", 32'(center_addr), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.cnt", 32'(max_count), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst.idle", 32'(busy), 32'd0);
    run_scan(1, 0, -1, 1, "rescan");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
